dut_result_checker: RTL and testbench
=====================================

Name: dut_result_checker

Overview:
- Scoreboard stage directly downstream of the top-level stimulus generator in the fabric test bench.
- Each clock, compares the fabric's data output against the expected output of the reference design, under a bit mask.
- Accumulates mismatch statistics over one clock-frequency trial, bounded by clock_finished, and drives clock_result back to the generator's max-clock binary search.
- Written as synchronous RTL. It has one simulation-only feature: X/Z detection on the DUT bus.

Parameters:
- DATA_OUT_WIRE_WIDTH, 36: width of the DUT and expected output buses.
- SETTLE_CYCLES, 3: clock edges ignored at trial start, covering the generator's zeroed warm-up cycles and pipeline fill. Legal range 0..15.
- CNT_WIDTH, 16: width of all counters. All counters saturate.

Ports:
- clk  in  1: fabric system clock. Its period varies per trial.
- sys_reset  in  1: asynchronous reset, active high.
- dut_dataout  in  DATA_OUT_WIRE_WIDTH: fabric output bus.
- expected_dataout  in  DATA_OUT_WIRE_WIDTH: reference-design output bus.
- compare_mask  in  DATA_OUT_WIRE_WIDTH: 1 means the bit is checked. Quasi-static.
- clock_finished  in  1: 0 means a trial is running; 0→1 means the trial has ended.
- clock_result  out  1: 1 means the current/last trial passed.
- result_valid  out  1: the trial has ended and the statistics are frozen.
- mismatch_count  out  CNT_WIDTH: number of failing compare cycles in this trial.
- checked_count  out  CNT_WIDTH: number of compare cycles in this trial.
- first_fail_bits  out  DATA_OUT_WIRE_WIDTH: masked XOR captured at the first failing cycle.
- first_fail_cycle  out  CNT_WIDTH: value of checked_count at the first failure.
- trial_count  out  CNT_WIDTH: number of completed trials since reset.

Behaviour:
- Reset (async, sys_reset=1):
  - state=IDLE.
  - All counters, first_fail_bits, first_fail_cycle and result_valid go to 0.
  - The settle counter also clears.
  - clock_result=0, because checked_count=0.
  - Reset mid-trial aborts the trial; trial_count is not incremented.
- clock_result is combinational from registered state: (checked_count!=0) && (mismatch_count==0).
  - It is therefore valid in the same delta as clock_finished rising, with no clock edge required. The generator samples it 5 ns later, asynchronously.
- fail_vec = (dut_dataout ^ expected_dataout) & compare_mask.
  - In simulation, any masked DUT bit that is X/Z also sets its fail_vec bit.
- States (all transitions on posedge clk):
  - IDLE: if clock_finished==0 → SETTLE; clear mismatch/checked/first_fail_*, result_valid=0, settle counter=0.
  - SETTLE: settle counter increments each edge. When it reaches SETTLE_CYCLES → CHECK. If SETTLE_CYCLES=0, go to CHECK on the first edge, with no compare on that edge.
  - CHECK: each edge, checked_count+1 (saturating). If fail_vec!=0, mismatch_count+1 (saturating). If fail_vec!=0 and mismatch_count==0, also capture first_fail_bits=fail_vec and first_fail_cycle=checked_count (pre-increment value).
  - Any state except IDLE/DONE: if clock_finished sampled 1 → DONE. The compare on that edge is not performed. result_valid=1, trial_count+1 (saturating).
  - SETTLE with clock_finished=1: enters DONE with checked_count=0, so clock_result=0. An empty trial fails.
  - DONE: statistics are held. clock_finished sampled 0 → SETTLE, with the same clears as IDLE→SETTLE, so back-to-back trials need no IDLE pass.
- Saturation:
  - All counters stick at 2^CNT_WIDTH-1.
  - A saturated mismatch_count still forces a fail.
- Bits with compare_mask=0 never contribute, including X/Z bits.
- clock_finished is sampled only on posedge clk; a pulse shorter than one period may be missed. The generator holds the level for many cycles, so this is acceptable.

Test Plan:
- Reset then clock_finished=0, dut=expected for 20 edges, SETTLE_CYCLES=3, then clock_finished=1 → checked_count=16, mismatch_count=0, clock_result=1 before the next edge, result_valid=1, trial_count=1.
- Same setup, but dut bit 5 is inverted on CHECK cycles 4 and 9 (0-based) → mismatch_count=2, first_fail_bits=0x20, first_fail_cycle=4, clock_result=0.
- compare_mask bit 5=0 with the same corruption as the previous scenario → mismatch_count=0, clock_result=1. An X on masked bit 5 is also ignored; an X on unmasked bit 0 → first_fail_bits=0x1.
- clock_finished=1 after only 2 edges (still in SETTLE) → checked_count=0, clock_result=0, trial_count increments.
- Two back-to-back trials, first failing and second clean → counters clear on DONE→SETTLE; second trial gives clock_result=1, trial_count=2.
- Assert sys_reset mid-CHECK with mismatch_count=3 → all outputs 0 immediately, without waiting for a clock edge; trial_count=0; the next trial proceeds normally.

Source files
------------

// File: rtl/dut_result_checker.sv
// Result checker for one clock-frequency trial of the fabric test bench.
// Compares the fabric output against the reference output under a bit mask,
// accumulates mismatch statistics between trial start and clock_finished,
// and reports pass/fail back to the generator's max-clock search.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for the first trial to start
// SETTLE | trial running, ignoring warm-up / pipeline-fill edges
// CHECK  | trial running, one compare per edge
// DONE   | trial ended, statistics frozen until the next trial starts
`timescale 1ns/1ps
module dut_result_checker #(
   parameter int DATA_OUT_WIRE_WIDTH = 36,
   parameter int SETTLE_CYCLES       = 3,
   parameter int CNT_WIDTH           = 16
) (
   input  logic                           clk,
   input  logic                           sys_reset,
   input  logic [DATA_OUT_WIRE_WIDTH-1:0] dut_dataout,
   input  logic [DATA_OUT_WIRE_WIDTH-1:0] expected_dataout,
   input  logic [DATA_OUT_WIRE_WIDTH-1:0] compare_mask,
   input  logic                           clock_finished,
   output logic                           clock_result,
   output logic                           result_valid,
   output logic [CNT_WIDTH-1:0]           mismatch_count,
   output logic [CNT_WIDTH-1:0]           checked_count,
   output logic [DATA_OUT_WIRE_WIDTH-1:0] first_fail_bits,
   output logic [CNT_WIDTH-1:0]           first_fail_cycle,
   output logic [CNT_WIDTH-1:0]           trial_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
   localparam logic [3:0]           SETTLE_TGT = 4'(SETTLE_CYCLES);

   state_t                           state;
   state_t                           state_next;
   logic [3:0]                       settle_cnt;
   logic                             settle_done;
   logic                             start_trial;
   logic                             settle_inc;
   logic                             do_compare;
   logic                             end_trial;
   logic [DATA_OUT_WIRE_WIDTH-1:0]   fail_vec;
   logic                             any_fail;

   // Settle phase ends on the edge that brings the counter to the target;
   // a zero target still spends exactly one non-comparing edge in SETTLE.
   assign settle_done = (SETTLE_CYCLES == 0) || ((settle_cnt + 4'd1) == SETTLE_TGT);

   // Masked per-bit mismatch. Written as an if/else so that an unknown
   // (X/Z) DUT bit in simulation falls into the "mismatch" branch, while
   // synthesis sees a plain masked XOR.
   always_comb begin
      fail_vec = '0;
      for (int i = 0; i < DATA_OUT_WIRE_WIDTH; i++) begin
         if (compare_mask[i]) begin
            if ((dut_dataout[i] ^ expected_dataout[i]) == 1'b0) begin
               fail_vec[i] = 1'b0;
            end else begin
               fail_vec[i] = 1'b1;
            end
         end
      end
   end

   assign any_fail = |fail_vec;

   // State register.
   always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and per-edge datapath strobes.
   always_comb begin
      state_next  = state;
      start_trial = 1'b0;
      settle_inc  = 1'b0;
      do_compare  = 1'b0;
      end_trial   = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (!clock_finished) begin
               state_next  = SETTLE;
               start_trial = 1'b1;
            end
         end
         SETTLE: begin
            if (clock_finished) begin
               state_next = DONE;
               end_trial  = 1'b1;
            end else begin
               settle_inc = 1'b1;
               if (settle_done) begin
                  state_next = CHECK;
               end
            end
         end
         CHECK: begin
            if (clock_finished) begin
               state_next = DONE;
               end_trial  = 1'b1;
            end else begin
               do_compare = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Settle counter: cleared at trial start, advanced on each settle edge.
   always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
         settle_cnt <= '0;
      end else if (start_trial) begin
         settle_cnt <= '0;
      end else if (settle_inc) begin
         settle_cnt <= settle_cnt + 4'd1;
      end
   end

   // Per-trial statistics: cleared at trial start, updated on compare edges.
   always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
         checked_count    <= '0;
         mismatch_count   <= '0;
         first_fail_bits  <= '0;
         first_fail_cycle <= '0;
      end else if (start_trial) begin
         checked_count    <= '0;
         mismatch_count   <= '0;
         first_fail_bits  <= '0;
         first_fail_cycle <= '0;
      end else if (do_compare) begin
         if (checked_count != CNT_MAX) begin
            checked_count <= checked_count + CNT_ONE;
         end
         if (any_fail) begin
            if (mismatch_count != CNT_MAX) begin
               mismatch_count <= mismatch_count + CNT_ONE;
            end
            if (mismatch_count == '0) begin
               first_fail_bits  <= fail_vec;
               first_fail_cycle <= checked_count;
            end
         end
      end
   end

   // Trial-end bookkeeping: freeze flag and completed-trial counter.
   always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
         result_valid <= 1'b0;
         trial_count  <= '0;
      end else if (start_trial) begin
         result_valid <= 1'b0;
      end else if (end_trial) begin
         result_valid <= 1'b1;
         if (trial_count != CNT_MAX) begin
            trial_count <= trial_count + CNT_ONE;
         end
      end
   end

   // Pass needs at least one compare and no failures; purely from registers
   // so it is already settled when clock_finished rises.
   assign clock_result = (checked_count != '0) && (mismatch_count == '0);

endmodule

// File: tb/tb_dut_result_checker.sv
// Bench for dut_result_checker: directed trial scenarios plus random trials,
// checked against a trial-level reference model.
`timescale 1ns/1ps
module tb_dut_result_checker;

   localparam int W         = 36;
   localparam int S         = 3;
   localparam int CW        = 16;
   localparam int CMAX      = (1 << CW) - 1;
   localparam int FIRST_CMP = ((S == 0) ? 1 : S) + 1;

   logic          clk = 1'b0;
   logic          sys_reset;
   logic [W-1:0]  dut_dataout;
   logic [W-1:0]  expected_dataout;
   logic [W-1:0]  compare_mask;
   logic          clock_finished;
   logic          clock_result;
   logic          result_valid;
   logic [CW-1:0] mismatch_count;
   logic [CW-1:0] checked_count;
   logic [W-1:0]  first_fail_bits;
   logic [CW-1:0] first_fail_cycle;
   logic [CW-1:0] trial_count;

   int total = 0;
   int bad   = 0;

   // reference model state (per trial, edge index k from trial start)
   bit           m_running;
   int           m_k;
   int           m_checked;
   int           m_mism;
   int           m_ffc;
   logic [W-1:0] m_ffb;
   bit           m_valid;
   int           m_trials;

   always #5 clk = ~clk;

   dut_result_checker #(
      .DATA_OUT_WIRE_WIDTH(W),
      .SETTLE_CYCLES      (S),
      .CNT_WIDTH          (CW)
   ) u_dut (
      .clk             (clk),
      .sys_reset       (sys_reset),
      .dut_dataout     (dut_dataout),
      .expected_dataout(expected_dataout),
      .compare_mask    (compare_mask),
      .clock_finished  (clock_finished),
      .clock_result    (clock_result),
      .result_valid    (result_valid),
      .mismatch_count  (mismatch_count),
      .checked_count   (checked_count),
      .first_fail_bits (first_fail_bits),
      .first_fail_cycle(first_fail_cycle),
      .trial_count     (trial_count)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_running = 1'b0;
      m_k       = 0;
      m_checked = 0;
      m_mism    = 0;
      m_ffc     = 0;
      m_ffb     = '0;
      m_valid   = 1'b0;
      m_trials  = 0;
   endfunction

   // One clock edge of the trial-level model: trials start when finished is
   // seen low outside a trial; the first FIRST_CMP edges are not compared;
   // an edge with finished high ends the trial without a compare.
   function automatic void model_edge(input logic [W-1:0] d, input logic [W-1:0] e,
                                      input logic [W-1:0] m, input logic fin);
      logic [W-1:0] fv;
      if (!m_running) begin
         if (fin === 1'b0) begin
            m_running = 1'b1;
            m_k       = 0;
            m_checked = 0;
            m_mism    = 0;
            m_ffb     = '0;
            m_ffc     = 0;
            m_valid   = 1'b0;
         end
      end else begin
         m_k++;
         if (fin === 1'b1) begin
            m_running = 1'b0;
            m_valid   = 1'b1;
            if (m_trials < CMAX) m_trials++;
         end else if (m_k >= FIRST_CMP) begin
            fv = '0;
            for (int i = 0; i < W; i++) begin
               if (m[i] === 1'b1 && d[i] !== e[i]) fv[i] = 1'b1;
            end
            if (fv != '0) begin
               if (m_mism == 0) begin
                  m_ffb = fv;
                  m_ffc = m_checked;
               end
               if (m_mism < CMAX) m_mism++;
            end
            if (m_checked < CMAX) m_checked++;
         end
      end
   endfunction

   function automatic logic [W-1:0] rnd_word();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_clock_result"},     clock_result,     ((m_checked != 0) && (m_mism == 0)) ? 1 : 0);
      chk({tag, "_result_valid"},     result_valid,     m_valid);
      chk({tag, "_mismatch_count"},   mismatch_count,   m_mism);
      chk({tag, "_checked_count"},    checked_count,    m_checked);
      chk({tag, "_first_fail_bits"},  first_fail_bits,  m_ffb);
      chk({tag, "_first_fail_cycle"}, first_fail_cycle, m_ffc);
      chk({tag, "_trial_count"},      trial_count,      m_trials);
   endtask

   // Drive one edge's inputs (called at a negedge), clock, return at negedge.
   task automatic step(input logic [W-1:0] d, input logic [W-1:0] e, input logic fin);
      dut_dataout      = d;
      expected_dataout = e;
      clock_finished   = fin;
      @(posedge clk);
      model_edge(d, e, compare_mask, fin);
      @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] w;
      logic [W-1:0] d;
      int           len;

      sys_reset        = 1'b1;
      clock_finished   = 1'b1;
      compare_mask     = '1;
      dut_dataout      = '0;
      expected_dataout = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all("reset");
      sys_reset = 1'b0;

      // clean trial: 20 running edges, 3 settle edges, 16 compares
      for (int i = 0; i < 20; i++) begin
         w = rnd_word();
         step(w, w, 1'b0);
      end
      check_all("clean_run");
      step(rnd_word(), rnd_word(), 1'b1);
      check_all("clean");
      chk("clean_checked_const", checked_count, 16);
      chk("clean_pass_const", clock_result, 1);
      chk("clean_trials_const", trial_count, 1);
      for (int i = 0; i < 3; i++) step(rnd_word(), rnd_word(), 1'b1);
      check_all("done_hold");

      // back-to-back failing trial: bit 5 flipped on compare cycles 4 and 9
      for (int i = 0; i < 20; i++) begin
         w = rnd_word();
         d = (i == FIRST_CMP + 4 || i == FIRST_CMP + 9) ? (w ^ 36'h20) : w;
         step(d, w, 1'b0);
      end
      step(rnd_word(), rnd_word(), 1'b1);
      check_all("bit5");
      chk("bit5_mism_const", mismatch_count, 2);
      chk("bit5_ffb_const", first_fail_bits, 36'h20);
      chk("bit5_ffc_const", first_fail_cycle, 4);

      // same corruption with bit 5 masked off, plus an unknown on masked bit 5
      compare_mask    = '1;
      compare_mask[5] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         w = rnd_word();
         d = (i == FIRST_CMP + 4 || i == FIRST_CMP + 9) ? (w ^ 36'h20) : w;
         if (i == FIRST_CMP + 12) d[5] = 1'bx;
         step(d, w, 1'b0);
      end
      step(rnd_word(), rnd_word(), 1'b1);
      check_all("masked");
      chk("masked_mism_const", mismatch_count, 0);
      chk("masked_trials_const", trial_count, 3);

      // unknown on unmasked bit 0 counts as a failing bit
      compare_mask = '1;
      for (int i = 0; i < 12; i++) begin
         w    = rnd_word();
         w[0] = 1'b1;
         d    = w;
         if (i == FIRST_CMP + 2) d[0] = 1'bx;
         step(d, w, 1'b0);
      end
      step(rnd_word(), rnd_word(), 1'b1);
      check_all("x_bit0");

      // trial ended while still settling: empty trial fails
      step(rnd_word(), rnd_word(), 1'b0);
      step(rnd_word(), rnd_word(), 1'b0);
      step(rnd_word(), rnd_word(), 1'b1);
      check_all("empty");
      chk("empty_checked_const", checked_count, 0);
      chk("empty_pass_const", clock_result, 0);

      // random trials with random masks and sparse single-bit corruption
      for (int t = 0; t < 10; t++) begin
         compare_mask = rnd_word();
         len = $urandom_range(0, 30);
         for (int i = 0; i < len; i++) begin
            w = rnd_word();
            d = ($urandom_range(0, 5) == 0) ? (w ^ (36'd1 << $urandom_range(0, W - 1))) : w;
            step(d, w, 1'b0);
            if (i % 7 == 6) check_all("rand_mid");
         end
         step(rnd_word(), rnd_word(), 1'b1);
         check_all("rand_end");
      end

      // reset in the middle of CHECK with three mismatches recorded
      compare_mask = '1;
      for (int i = 0; i < 12; i++) begin
         w = rnd_word();
         d = (i >= FIRST_CMP && i < FIRST_CMP + 3) ? ~w : w;
         step(d, w, 1'b0);
      end
      check_all("pre_reset");
      chk("pre_reset_mism_const", mismatch_count, 3);
      #2;
      sys_reset = 1'b1;
      model_reset();
      #1;
      check_all("mid_reset");
      chk("mid_reset_trials_const", trial_count, 0);
      @(negedge clk);
      sys_reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         w = rnd_word();
         step(w, w, 1'b0);
      end
      step(rnd_word(), rnd_word(), 1'b1);
      check_all("after_reset");
      chk("after_reset_trials_const", trial_count, 1);

      // counter saturation: every compare fails for longer than the range
      for (int i = 0; i < CMAX + 10; i++) begin
         step(36'h0, 36'h1, 1'b0);
      end
      check_all("sat_run");
      step(36'h0, 36'h1, 1'b1);
      check_all("sat");
      chk("sat_checked_const", checked_count, CMAX);
      chk("sat_mism_const", mismatch_count, CMAX);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
